// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets four requesters share one external 4-input adder.
// One transaction at a time: IDLE grants, ISSUE captures the adder result, HOLD waits for rsp_ready.
module adder_arbiter #(
   parameter int W = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      req_valid,
   input  logic [16*W-1:0] req_ops,
   output logic [3:0]      req_ready,
   output logic [W-1:0]    add_a,
   output logic [W-1:0]    add_b,
   output logic [W-1:0]    add_c,
   output logic [W-1:0]    add_d,
   input  logic [W-1:0]    add_sum,
   input  logic            add_ov,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [1:0]      rsp_id,
   output logic [W-1:0]    rsp_sum,
   output logic            rsp_ov,
   output logic            busy,
   output logic [7:0]      txn_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

   state_t         state_q, state_d;
   logic [1:0]     last_id_q, last_id_d;
   logic [W-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
   logic [W-1:0]   add_c_q, add_c_d, add_d_q, add_d_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [1:0]     rsp_id_q, rsp_id_d;
   logic [W-1:0]   rsp_sum_q, rsp_sum_d;
   logic           rsp_ov_q, rsp_ov_d;
   logic [7:0]     txn_count_q, txn_count_d;

   logic           grant_found;
   logic [1:0]     grant_id;
   logic [1:0]     idx;
   logic [4*W-1:0] sel_ops;
   logic           transfer;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin
      grant_found = 1'b0;
      grant_id    = last_id_q;
      idx         = last_id_q;
      for (int k = 1; k <= 4; k++) begin
         idx = last_id_q + 2'(k);
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   // Gated by rst so no grant is offered while reset holds the FSM in IDLE.
   assign req_ready = (state_q == IDLE && rst && grant_found) ? (4'(1) << grant_id) : 4'b0000;
   assign transfer  = |(req_valid & req_ready);
   assign sel_ops   = req_ops[32'(grant_id) * 4 * W +: 4 * W];

   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      add_c_d     = add_c_q;
      add_d_d     = add_d_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_ov_d    = rsp_ov_q;
      txn_count_d = txn_count_q;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               add_a_d   = sel_ops[0*W +: W];
               add_b_d   = sel_ops[1*W +: W];
               add_c_d   = sel_ops[2*W +: W];
               add_d_d   = sel_ops[3*W +: W];
               rsp_id_d  = grant_id;
               last_id_d = grant_id;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            rsp_sum_d   = add_sum;
            rsp_ov_d    = add_ov;
            rsp_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               txn_count_d = txn_count_q + 8'd1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         last_id_q   <= 2'd3;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_c_q     <= '0;
         add_d_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 2'd0;
         rsp_sum_q   <= '0;
         rsp_ov_q    <= 1'b0;
         txn_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_c_q     <= add_c_d;
         add_d_q     <= add_d_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_ov_q    <= rsp_ov_d;
         txn_count_q <= txn_count_d;
      end
   end

   assign add_a     = add_a_q;
   assign add_b     = add_b_q;
   assign add_c     = add_c_q;
   assign add_d     = add_d_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_ov    = rsp_ov_q;
   assign busy      = (state_q != IDLE);
   assign txn_count = txn_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter; models the shared adder and checks hand-computed results.
module tb_adder_arbiter;
   localparam int W = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req_valid;
   logic [16*W-1:0] req_ops;
   logic [3:0]      req_ready;
   logic [W-1:0]    add_a, add_b, add_c, add_d;
   logic [W-1:0]    add_sum;
   logic            add_ov;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [1:0]      rsp_id;
   logic [W-1:0]    rsp_sum;
   logic            rsp_ov;
   logic            busy;
   logic [7:0]      txn_count;
   logic [W+1:0]    total;

   int n_checks = 0;
   int n_errors = 0;

   adder_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ops(req_ops), .req_ready(req_ready),
      .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
      .add_sum(add_sum), .add_ov(add_ov),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_ov(rsp_ov), .busy(busy), .txn_count(txn_count)
   );

   // Shared adder model outside the DUT
   assign total   = {2'b00, add_a} + {2'b00, add_b} + {2'b00, add_c} + {2'b00, add_d};
   assign add_sum = total[W-1:0];
   assign add_ov  = |total[W+1:W];

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c, input logic [W-1:0] d);
      req_ops[i*4*W +: 4*W] = {d, c, b, a};
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 4'b1111;
      req_ops   = '1;
      rsp_ready = 1'b0;
      tick();
      tick();
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_txn_count", 32'(txn_count), 32'h0);
      check("rst_add_ops", 32'({add_d, add_c, add_b, add_a}), 32'h0);

      // Single request from requester 0
      req_valid = 4'b0000;
      rst = 1'b1;
      tick();
      set_ops(0, 4'd3, 4'd4, 4'd5, 4'd2);
      req_valid = 4'b0001;
      #1;
      check("single_grant", 32'(req_ready), 32'h1);
      tick();
      req_valid = 4'b0000;
      check("single_busy_issue", 32'(busy), 32'h1);
      check("single_no_rsp_yet", 32'(rsp_valid), 32'h0);
      check("single_add_ops", 32'({add_d, add_c, add_b, add_a}), 32'h2543);
      tick();
      check("single_rsp_valid", 32'(rsp_valid), 32'h1);
      check("single_rsp_id", 32'(rsp_id), 32'h0);
      check("single_rsp_sum", 32'(rsp_sum), 32'd14);
      check("single_rsp_ov", 32'(rsp_ov), 32'h0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("single_done_valid", 32'(rsp_valid), 32'h0);
      check("single_txn_count", 32'(txn_count), 32'd1);
      check("single_idle_busy", 32'(busy), 32'h0);

      // Overflow from requester 2, then backpressure
      set_ops(2, 4'd15, 4'd15, 4'd15, 4'd15);
      req_valid = 4'b0100;
      #1;
      check("ov_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b1111;
      #1;
      check("ov_issue_no_grant", 32'(req_ready), 32'h0);
      tick();
      check("ov_rsp_id", 32'(rsp_id), 32'd2);
      check("ov_rsp_sum", 32'(rsp_sum), 32'd12);
      check("ov_rsp_ov", 32'(rsp_ov), 32'h1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
         check("bp_rsp_sum", 32'({rsp_ov, rsp_id, rsp_sum}), 32'({1'b1, 2'd2, 4'd12}));
         check("bp_req_ready", 32'(req_ready), 32'h0);
         check("bp_busy", 32'(busy), 32'h1);
      end
      rsp_ready = 1'b1;
      tick();
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      check("bp_release_valid", 32'(rsp_valid), 32'h0);
      check("bp_txn_count", 32'(txn_count), 32'd2);

      // Reset in ISSUE discards the transaction
      req_valid = 4'b0100;
      #1;
      check("mid_grant", 32'(req_ready), 32'h4);
      tick();
      req_valid = 4'b0000;
      check("mid_in_issue", 32'(busy), 32'h1);
      rst = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_txn", 32'(txn_count), 32'h0);
      #1;
      rst = 1'b1;
      tick();
      tick();
      check("mid_after_valid", 32'(rsp_valid), 32'h0);
      check("mid_after_txn", 32'(txn_count), 32'h0);

      // Request withdrawn before transfer must not move the pointer
      req_valid = 4'b0010;
      #1;
      check("drop_grant", 32'(req_ready), 32'h2);
      req_valid = 4'b0000;
      tick();
      check("drop_no_busy", 32'(busy), 32'h0);
      req_valid = 4'b0101;
      #1;
      check("post_rst_grant", 32'(req_ready), 32'h1);

      // Round robin with all requesters active
      for (int i = 0; i < 4; i++) set_ops(i, 4'(i), 4'd1, 4'd2, 4'(i));
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("rr_grant", 32'(req_ready), 32'(4'(1) << (k % 4)));
         tick();
         check("rr_issue_ready", 32'(req_ready), 32'h0);
         tick();
         check("rr_rsp_valid", 32'(rsp_valid), 32'h1);
         check("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
         check("rr_rsp_sum", 32'(rsp_sum), 32'(2 * (k % 4) + 3));
         tick();
      end
      check("rr_txn_count", 32'(txn_count), 32'd5);

      // Counter wraparound
      req_valid = 4'b0001;
      for (int k = 0; k < 250; k++) begin
         tick();
         tick();
         tick();
      end
      check("wrap_255", 32'(txn_count), 32'd255);
      tick();
      tick();
      tick();
      check("wrap_0", 32'(txn_count), 32'd0);
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
